alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Registered output stage directly downstream of the ALU. Captures each ALU result with its
//  operands and opcode, computes status flags (zero, negative, signed overflow, illegal-op),
//  and presents them to the consumer through a 2-entry skid buffer with valid/ready handshake.
//  Decouples combinational ALU timing from the write-back path; absorbs one cycle of backpressure.
// PARAMETERS
//  WORDSIZE  64  data width of operands and result (two's complement)
//  OPW       5   opcode width; must match the ALU op port
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         asynchronous, active-low reset
//  in_valid     in   1         ALU result/operands/op valid this cycle
//  in_ready     out  1         stage can accept; registered, not combinational from out_ready
//  in_a         in   WORDSIZE  operand a as presented to the ALU
//  in_b         in   WORDSIZE  operand b as presented to the ALU
//  in_op        in   OPW       opcode as presented to the ALU
//  in_result    in   WORDSIZE  ALU result
//  out_valid    out  1         head entry valid
//  out_ready    in   1         consumer accepts head entry
//  out_result   out  WORDSIZE  head result
//  out_op       out  OPW       head opcode
//  out_zero     out  1         head result == 0
//  out_neg      out  1         head result MSB
//  out_ovf      out  1         signed overflow on add/sub; 0 otherwise
//  out_illegal  out  1         head opcode not in {GET_A, GET_B, ADD, SUB}
// BEHAVIOUR
//  - Reset (rst_n low, async): state EMPTY; out_valid=0, in_ready=1, all data/flag outputs 0.
//  - Transfer in: in_valid & in_ready at clk edge. Transfer out: out_valid & out_ready at edge.
//  - Latency: accepted entry appears on out_* the following cycle when buffer was EMPTY.
//  - FSM (entry count): EMPTY, ONE, TWO.
//    EMPTY: in xfer -> ONE.
//    ONE:   in only -> TWO; out only -> EMPTY; both or neither -> ONE (head replaced when both).
//    TWO:   in_ready=0; out xfer -> ONE (second entry becomes head); else hold.
//  - in_ready = (state != TWO), driven from state register only.
//  - Order strictly FIFO; no entry dropped or duplicated; out_* stable while out_valid & ~out_ready.
//  - Flags computed on input side (before storage), stored with the entry:
//    zero = (in_result == 0); neg = in_result[WORDSIZE-1];
//    ADD ovf = (a[MSB]==b[MSB]) & (res[MSB]!=a[MSB]);
//    SUB ovf = (a[MSB]!=b[MSB]) & (res[MSB]!=a[MSB]);
//    GET_A/GET_B/illegal: ovf=0. illegal=1 for any op outside 0..3 (result expected 0, passed as-is).
//  - in_valid while in_ready=0: ignored; upstream must hold. No error signalled.
//  - Reset mid-operation: all buffered entries discarded immediately; no partial output.
//  - Opcodes 5'b00000 GET_A, 5'b00001 GET_B, 5'b00010 ADD, 5'b00011 SUB.
// STRUCTURE
//  - Shared package alu_pkg: OPW, opcode localparams (OP_GET_A..OP_SUB), flag-bundle typedef
//    {zero,neg,ovf,illegal}; the ALU is migrated to the same constants.
//  - Sub-module alu_flags (combinational: a, b, op, result -> flag bundle); instantiated once.
//  - Storage: two entry registers (head, tail) + 2-bit state; no generic FIFO instance.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with 2 entries held -> out_valid=0, in_ready=1 same cycle.
//  2 Single pass, out_ready=1: ADD a=5 b=3 res=8 -> next cycle out_result=8, zero=0, neg=0, ovf=0.
//  3 Overflow (WORDSIZE=64): ADD a=0x7FFF..F b=1 res=0x8000..0 -> ovf=1, neg=1;
//    SUB a=0x8000..0 b=1 res=0x7FFF..F -> ovf=1, neg=0; GET_A a=0 -> zero=1, ovf=0.
//  4 Backpressure: out_ready=0, push 3 results 10,20,30 -> in_ready=0 after 2nd; 30 held upstream;
//    release out_ready -> outputs 10,20,30 in order, none lost/duplicated.
//  5 Simultaneous in/out in ONE for 100 cycles of random results -> throughput 1/cycle, order kept.
//  6 Illegal op 5'b10101 res=0 -> out_illegal=1, zero=1, ovf=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width, opcode encodings, status flag bundle, fill-state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_GET_A = 5'b00000;
  localparam logic [OPW-1:0] OP_GET_B = 5'b00001;
  localparam logic [OPW-1:0] OP_ADD   = 5'b00010;
  localparam logic [OPW-1:0] OP_SUB   = 5'b00011;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
    logic illegal;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fill_state_t;

  // True for the four opcodes the ALU actually implements.
  function automatic logic is_legal_op(input logic [OPW-1:0] op);
    return (op == OP_GET_A) || (op == OP_GET_B) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_flags.sv
// Derives zero/negative/signed-overflow/illegal-op flags from an ALU transaction.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module alu_flags
  import alu_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [WORDSIZE-1:0] a,
  input  logic [WORDSIZE-1:0] b,
  input  logic [OPW-1:0]      op,
  input  logic [WORDSIZE-1:0] result,
  output alu_flags_t          flags
);

  localparam int MSB = WORDSIZE - 1;

  // Overflow looks only at sign bits: operands agree (add) or differ (sub) and the result sign flipped.
  always_comb begin
    flags         = '0;
    flags.zero    = (result == '0);
    flags.neg     = result[MSB];
    flags.illegal = !is_legal_op(op);
    case (op)
      OP_ADD:  flags.ovf = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      OP_SUB:  flags.ovf = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      default: flags.ovf = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registers ALU results with their flags and hands them to write-back through a 2-entry skid buffer.
// Latency: one cycle from input transfer to out_valid when the buffer is empty.
// Backpressure: absorbs one stalled cycle; in_ready comes from the state register only.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] in_a,
  input  logic [WORDSIZE-1:0] in_b,
  input  logic [OPW-1:0]      in_op,
  input  logic [WORDSIZE-1:0] in_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_result,
  output logic [OPW-1:0]      out_op,
  output logic                out_zero,
  output logic                out_neg,
  output logic                out_ovf,
  output logic                out_illegal
);

  typedef struct packed {
    logic [WORDSIZE-1:0] result;
    logic [OPW-1:0]      op;
    alu_flags_t          flags;
  } entry_t;

  fill_state_t state_q, state_d;
  entry_t      head_q, tail_q;
  entry_t      in_entry;
  alu_flags_t  in_flags;

  logic in_xfer;
  logic out_xfer;
  logic load_head_in;
  logic load_head_tail;
  logic load_tail_in;

  // Flags are resolved before storage so the output side is a plain register read.
  alu_flags #(
    .WORDSIZE(WORDSIZE)
  ) u_flags (
    .a      (in_a),
    .b      (in_b),
    .op     (in_op),
    .result (in_result),
    .flags  (in_flags)
  );

  assign in_entry = '{result: in_result, op: in_op, flags: in_flags};

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Next fill state and which entry register is written this cycle.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail_in   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          load_head_in = 1'b1;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          // Head leaves and the new entry takes its place: full throughput.
          load_head_in = 1'b1;
        end else if (in_xfer) begin
          load_tail_in = 1'b1;
          state_d      = ST_TWO;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          load_head_tail = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Fill-state register; reset discards everything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Entry storage; head drives the outputs directly so they stay stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head_in) begin
        head_q <= in_entry;
      end else if (load_head_tail) begin
        head_q <= tail_q;
      end
      if (load_tail_in) begin
        tail_q <= in_entry;
      end
    end
  end

  assign out_result  = head_q.result;
  assign out_op      = head_q.op;
  assign out_zero    = head_q.flags.zero;
  assign out_neg     = head_q.flags.neg;
  assign out_ovf     = head_q.flags.ovf;
  assign out_illegal = head_q.flags.illegal;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   op;
    logic [W-1:0] res;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [4:0]   in_op;
  logic [W-1:0] in_result;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [4:0]   out_op;
  logic         out_zero;
  logic         out_neg;
  logic         out_ovf;
  logic         out_illegal;

  alu_result_stage #(.WORDSIZE(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_result   (in_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_op      (out_op),
    .out_zero    (out_zero),
    .out_neg     (out_neg),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_pop   = 0;
  txn_t         model_q[$];
  logic [W-1:0] out_log[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: what the ALU result means, using ordinary signed arithmetic.
  function automatic logic [W-1:0] ref_result(input logic [4:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    case (op)
      5'd0:    return a;
      5'd1:    return b;
      5'd2:    return a + b;
      5'd3:    return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_ovf(input txn_t t);
    logic signed [W:0] wide;
    if (t.op == 5'd2) wide = $signed({t.a[W-1], t.a}) + $signed({t.b[W-1], t.b});
    else if (t.op == 5'd3) wide = $signed({t.a[W-1], t.a}) - $signed({t.b[W-1], t.b});
    else return 1'b0;
    // Result fits in W bits exactly when the wide sum equals its own truncation sign-extended.
    return wide[W] != wide[W-1];
  endfunction

  function automatic txn_t mk(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    txn_t t;
    t.a = a; t.b = b; t.op = op; t.res = ref_result(op, a, b);
    return t;
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 64'h7FFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'(int'($urandom_range(0, 3)) - 1);
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  function automatic txn_t rand_txn();
    logic [4:0] op;
    op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3));
    return mk(op, rand_word(), rand_word());
  endfunction

  // Compare every visible output against the model's head entry.
  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, W'(out_valid), W'(model_q.size() != 0));
    chk({tag, ".in_ready"}, W'(in_ready), W'(model_q.size() < 2));
    if (model_q.size() != 0) begin
      chk({tag, ".result"}, out_result, model_q[0].res);
      chk({tag, ".op"}, W'(out_op), W'(model_q[0].op));
      chk({tag, ".zero"}, W'(out_zero), W'(model_q[0].res == 0));
      chk({tag, ".neg"}, W'(out_neg), W'($signed(model_q[0].res) < 0));
      chk({tag, ".ovf"}, W'(out_ovf), W'(ref_ovf(model_q[0])));
      chk({tag, ".illegal"}, W'(out_illegal), W'(model_q[0].op > 5'd3));
    end
  endtask

  // One clock: check at the falling edge, drive, advance, update model, return to falling edge.
  task automatic cycle(input string tag, input logic vld, input txn_t t, input logic ordy,
                       output logic acc);
    logic pop;
    check_outputs(tag);
    in_valid  = vld;
    in_a      = t.a;
    in_b      = t.b;
    in_op     = t.op;
    in_result = t.res;
    out_ready = ordy;
    acc = vld && (model_q.size() < 2);
    pop = ordy && (model_q.size() != 0);
    if (pop) out_log.push_back(out_result);
    @(posedge clk);
    if (pop) begin
      void'(model_q.pop_front());
      n_pop++;
    end
    if (acc) model_q.push_back(t);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    logic acc;
    txn_t idle;
    idle = mk(5'd0, '0, '0);
    for (int i = 0; i < 8 && model_q.size() != 0; i++) cycle(tag, 1'b0, idle, 1'b1, acc);
    chk({tag, ".drained"}, W'(model_q.size()), W'(0));
  endtask

  // Push one transaction into an empty stage and check its flags the cycle after.
  task automatic push_check(input string tag, input txn_t t, input logic [W-1:0] exp_res,
                            input logic z, input logic n, input logic v, input logic il);
    logic acc;
    cycle(tag, 1'b1, t, 1'b1, acc);
    in_valid = 1'b0;
    chk({tag, ".vld"}, W'(out_valid), W'(1));
    chk({tag, ".res"}, out_result, exp_res);
    chk({tag, ".zero"}, W'(out_zero), W'(z));
    chk({tag, ".neg"}, W'(out_neg), W'(n));
    chk({tag, ".ovf"}, W'(out_ovf), W'(v));
    chk({tag, ".illegal"}, W'(out_illegal), W'(il));
    drain(tag);
  endtask

  initial begin
    logic acc;
    txn_t t;
    txn_t idle;
    int   pop0;
    idle = mk(5'd0, '0, '0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_result = '0;
    #2;
    chk("rst.out_valid", W'(out_valid), W'(0));
    chk("rst.in_ready", W'(in_ready), W'(1));
    chk("rst.result", out_result, W'(0));
    chk("rst.flags", W'({out_zero, out_neg, out_ovf, out_illegal}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single pass and overflow corners.
    push_check("add5p3", mk(5'd2, 64'd5, 64'd3), 64'd8, 0, 0, 0, 0);
    push_check("add_ovf", mk(5'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1), 64'h8000_0000_0000_0000, 0, 1, 1, 0);
    push_check("sub_ovf", mk(5'd3, 64'h8000_0000_0000_0000, 64'd1), 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 0);
    push_check("geta0", mk(5'd0, 64'd0, 64'd9), 64'd0, 1, 0, 0, 0);
    push_check("illegal", mk(5'b10101, 64'd4, 64'd7), 64'd0, 1, 0, 0, 1);

    // Backpressure: third push is held upstream until the consumer drains.
    out_log.delete();
    cycle("bp1", 1'b1, mk(5'd0, 64'd10, 0), 1'b0, acc);
    cycle("bp2", 1'b1, mk(5'd0, 64'd20, 0), 1'b0, acc);
    chk("bp.in_ready_full", W'(in_ready), W'(0));
    t = mk(5'd0, 64'd30, 0);
    for (int i = 0; i < 2; i++) cycle("bp_hold", 1'b1, t, 1'b0, acc);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cycle("bp_rel", 1'b1, t, 1'b1, acc);
    chk("bp.accepted30", W'(acc), W'(1));
    in_valid = 1'b0;
    drain("bp_drain");
    chk("bp.count", W'(out_log.size()), W'(3));
    if (out_log.size() == 3) begin
      chk("bp.first", out_log[0], 64'd10);
      chk("bp.second", out_log[1], 64'd20);
      chk("bp.third", out_log[2], 64'd30);
    end

    // Sustained simultaneous in/out while holding one entry.
    cycle("tp_prime", 1'b1, rand_txn(), 1'b0, acc);
    pop0 = n_pop;
    for (int i = 0; i < 100; i++) cycle("tp", 1'b1, rand_txn(), 1'b1, acc);
    chk("tp.pops", W'(n_pop - pop0), W'(100));
    chk("tp.occupancy", W'(model_q.size()), W'(1));
    in_valid = 1'b0;
    drain("tp_drain");

    // Random traffic with upstream holding unaccepted data.
    t = rand_txn();
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", ($urandom_range(0, 3) != 0), t, ($urandom_range(0, 2) != 0), acc);
      if (acc) t = rand_txn();
    end
    in_valid = 1'b0;
    drain("rnd_drain");

    // Reset with two entries held.
    cycle("rf1", 1'b1, rand_txn(), 1'b0, acc);
    cycle("rf2", 1'b1, rand_txn(), 1'b0, acc);
    chk("rf.full", W'(in_ready), W'(0));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", W'(out_valid), W'(0));
    chk("midrst.in_ready", W'(in_ready), W'(1));
    chk("midrst.result", out_result, W'(0));
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst", 1'b0, idle, 1'b1, acc);
    cycle("post_rst2", 1'b0, idle, 1'b1, acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
